// File: rtl/pointer_mem_access.sv
// Pointer-based data memory access: label lookup, bounds check, single access per request.
module pointer_mem_access #(
    parameter int unsigned LBID_W    = 12,
    parameter int unsigned OFS_W     = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LBL_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lt_we,
    input  logic [LBID_W-1:0] lt_idx,
    input  logic [ADDR_W-1:0] lt_base,
    input  logic [OFS_W:0]    lt_len,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LBID_W-1:0] req_lbid,
    input  logic [OFS_W-1:0]  req_ofs,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [1:0]        rsp_fault,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned IDX_W = (LBL_DEPTH > 1) ? $clog2(LBL_DEPTH) : 1;
    localparam int unsigned LEN_W = OFS_W + 1;

    localparam logic [1:0] FLT_OK    = 2'd0;
    localparam logic [1:0] FLT_RANGE = 2'd1;
    localparam logic [1:0] FLT_INVAL = 2'd2;
    localparam logic [1:0] FLT_OOB   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_n;

    // Label table storage
    logic [ADDR_W-1:0]    lbl_base_q [LBL_DEPTH];
    logic [LEN_W-1:0]     lbl_len_q  [LBL_DEPTH];
    logic [LBL_DEPTH-1:0] lbl_valid_q;

    // Latched request
    logic [LBID_W-1:0] lbid_q;
    logic [OFS_W-1:0]  ofs_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    // Next values of registered outputs
    logic              req_ready_n;
    logic              rsp_valid_n;
    logic [1:0]        rsp_fault_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic              mem_en_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;

    logic             lt_wr;
    logic [IDX_W-1:0] lt_sel;
    logic             accept;

    logic             lk_range;
    logic [IDX_W-1:0] lk_sel;
    logic             lk_valid;
    logic             lk_oob;
    logic [ADDR_W-1:0] lk_addr;

    assign lt_wr  = lt_we && (32'(lt_idx) < LBL_DEPTH);
    assign lt_sel = lt_idx[IDX_W-1:0];
    assign accept = req_valid && req_ready;

    // Lookup uses table contents as they stood before the current edge
    assign lk_sel   = lbid_q[IDX_W-1:0];
    assign lk_range = (32'(lbid_q) >= LBL_DEPTH);
    assign lk_valid = lbl_valid_q[lk_sel];
    assign lk_oob   = (LEN_W'(ofs_q) >= lbl_len_q[lk_sel]);
    assign lk_addr  = lbl_base_q[lk_sel] + ADDR_W'(ofs_q);

    // Label table payload (no reset needed: gated by valid bits)
    always_ff @(posedge clk) begin
        if (lt_wr) begin
            lbl_base_q[lt_sel] <= lt_base;
            lbl_len_q[lt_sel]  <= lt_len;
        end
    end

    // Label valid bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lbl_valid_q <= '0;
        end else if (lt_wr) begin
            lbl_valid_q[lt_sel] <= 1'b1;
        end
    end

    // Request capture on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lbid_q  <= '0;
            ofs_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            lbid_q  <= req_lbid;
            ofs_q   <= req_ofs;
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_n     = state;
        rsp_valid_n = 1'b0;
        rsp_fault_n = rsp_fault;
        rsp_rdata_n = rsp_rdata;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lk_range || !lk_valid || lk_oob) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                    if (lk_range) begin
                        rsp_fault_n = FLT_RANGE;
                    end else if (!lk_valid) begin
                        rsp_fault_n = FLT_INVAL;
                    end else begin
                        rsp_fault_n = FLT_OOB;
                    end
                end else begin
                    state_n     = S_ISSUE;
                    mem_en_n    = 1'b1;
                    mem_we_n    = we_q;
                    mem_addr_n  = lk_addr;
                    mem_wdata_n = wdata_q;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_n     = S_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_fault_n = FLT_OK;
                    rsp_rdata_n = '0;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                state_n     = S_RESP;
                rsp_valid_n = 1'b1;
                rsp_fault_n = FLT_OK;
                rsp_rdata_n = mem_rdata;
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        req_ready_n = (state_n == S_IDLE);
    end

    // Output registers, aligned with the state they belong to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_fault <= FLT_OK;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_fault <= rsp_fault_n;
            rsp_rdata <= rsp_rdata_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

endmodule
